// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// parameter defaults and the 16-bit word address type.
package fetch_pkg;

    typedef logic [15:0] addr_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam addr_t PC_STEP_DEFAULT  = 16'd1;
    localparam int    MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory bus: request/address out of the fetch unit,
// acknowledge/read data back from memory (ack and rdata valid together).
interface instr_fetch_if;
    import fetch_pkg::*;

    logic  imem_req;
    addr_t imem_addr;
    logic  imem_ack;
    addr_t imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_wait_timer.sv
// Counts consecutive cycles spent waiting for a memory acknowledge.
// expired is raised during the MAX_WAIT-th consecutive waiting cycle,
// so the owner can leave on the edge where the count reaches MAX_WAIT.
module fetch_wait_timer
    import fetch_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic Pc_Rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise advance while waiting.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    // Wait counter register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge Pc_Rst) begin
        if (!Pc_Rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: requests words from instruction memory at the
// PC, hands them to the decoder with a valid/ready handshake, drives the
// external PC register's load strobe, handles redirects and flags a
// sticky error when memory never answers.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter addr_t PC_STEP  = PC_STEP_DEFAULT,
    parameter int    MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic          clk,
    input  logic          Pc_Rst,
    input  addr_t         inst_addr,
    output logic          Pc_Ld,
    output addr_t         Pc_addr_in,
    instr_fetch_if.master imem,
    output addr_t         ir_out,
    output addr_t         ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          br_taken,
    input  addr_t         br_target,
    input  logic          halt,
    output logic          imem_err
);

    logic [2:0] state_q, state_d;
    addr_t      fetchAddr_q, fetchAddr_d;
    addr_t      irOut_q, irOut_d;
    addr_t      irPc_q, irPc_d;
    logic       irValid_q, irValid_d;
    logic       imemErr_q, imemErr_d;

    logic       pcLoad;
    addr_t      pcNext;
    logic       reEnter;
    logic       waiting;
    logic       timerClear;
    logic       timerExpired;

    assign waiting    = ((state_q == ST_FETCH) || (state_q == ST_FLUSH)) && !imem.imem_ack;
    assign timerClear = imem.imem_ack || reEnter || (state_d != state_q);

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .Pc_Rst  (Pc_Rst),
        .clear   (timerClear),
        .enable  (waiting),
        .expired (timerExpired)
    );

    // Next-state, PC-load and instruction-register decisions for each state.
    always_comb begin
        state_d     = state_q;
        fetchAddr_d = fetchAddr_q;
        irOut_d     = irOut_q;
        irPc_d      = irPc_q;
        irValid_d   = irValid_q;
        imemErr_d   = imemErr_q;
        pcLoad      = 1'b0;
        pcNext      = '0;
        reEnter     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (br_taken) begin
                    pcLoad = 1'b1;
                    pcNext = br_target;
                end else if (!halt) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (br_taken) begin
                    pcLoad = 1'b1;
                    pcNext = br_target;
                    if (imem.imem_ack) begin
                        state_d = ST_FETCH;
                        reEnter = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else if (imem.imem_ack) begin
                    pcLoad    = 1'b1;
                    pcNext    = fetchAddr_q + PC_STEP;
                    irOut_d   = imem.imem_rdata;
                    irPc_d    = fetchAddr_q;
                    irValid_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (timerExpired) begin
                    imemErr_d = 1'b1;
                    irValid_d = 1'b0;
                    state_d   = ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (br_taken) begin
                    pcLoad    = 1'b1;
                    pcNext    = br_target;
                    irValid_d = 1'b0;
                    state_d   = ST_FETCH;
                end else if (irValid_q && ir_ready) begin
                    irValid_d = 1'b0;
                    state_d   = halt ? ST_IDLE : ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (br_taken) begin
                    pcLoad = 1'b1;
                    pcNext = br_target;
                end
                if (imem.imem_ack) begin
                    state_d = ST_FETCH;
                end else if (timerExpired) begin
                    imemErr_d = 1'b1;
                    irValid_d = 1'b0;
                    state_d   = ST_ERROR;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // On FETCH entry capture the PC as it will read after this edge:
        // a simultaneous load would otherwise leave inst_addr one cycle stale.
        if ((state_d == ST_FETCH) && ((state_q != ST_FETCH) || reEnter)) begin
            fetchAddr_d = pcLoad ? pcNext : inst_addr;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge Pc_Rst) begin
        if (!Pc_Rst) begin
            state_q     <= ST_IDLE;
            fetchAddr_q <= '0;
            irOut_q     <= '0;
            irPc_q      <= '0;
            irValid_q   <= 1'b0;
            imemErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetchAddr_q <= fetchAddr_d;
            irOut_q     <= irOut_d;
            irPc_q      <= irPc_d;
            irValid_q   <= irValid_d;
            imemErr_q   <= imemErr_d;
        end
    end

    assign Pc_Ld          = Pc_Rst && pcLoad;
    assign Pc_addr_in     = (Pc_Rst && pcLoad) ? pcNext : '0;
    assign imem.imem_req  = Pc_Rst && ((state_q == ST_FETCH) || (state_q == ST_FLUSH));
    assign imem.imem_addr = fetchAddr_q;
    assign ir_out         = irOut_q;
    assign ir_pc          = irPc_q;
    assign ir_valid       = irValid_q;
    assign imem_err       = imemErr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: models the external PC register and a
// simple instruction memory (auto zero-wait or manually driven ack).
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        Pc_Rst = 1'b0;
    logic [15:0] pcReg = 16'd0;
    logic        pcForce = 1'b0;
    logic [15:0] pcForceVal = 16'd0;
    logic        Pc_Ld;
    logic [15:0] Pc_addr_in;
    logic [15:0] ir_out;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'd0;
    logic        halt = 1'b1;
    logic        imem_err;
    logic        autoAck = 1'b0;
    logic        manualAck = 1'b0;
    logic [15:0] manualData = 16'd0;

    int asserts = 0;
    int failures = 0;

    instr_fetch_if mif();

    assign mif.imem_ack   = autoAck ? mif.imem_req : manualAck;
    assign mif.imem_rdata = autoAck ? ~mif.imem_addr : manualData;

    instr_fetch #(.PC_STEP(16'd1), .MAX_WAIT(15)) dut (
        .clk        (clk),
        .Pc_Rst     (Pc_Rst),
        .inst_addr  (pcReg),
        .Pc_Ld      (Pc_Ld),
        .Pc_addr_in (Pc_addr_in),
        .imem       (mif),
        .ir_out     (ir_out),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .halt       (halt),
        .imem_err   (imem_err)
    );

    always #5 clk = ~clk;

    // External PC register, with a bench-side override to preset it.
    always @(posedge clk) begin
        if (pcForce) pcReg <= pcForceVal;
        else if (Pc_Ld) pcReg <= Pc_addr_in;
    end

    task tick;
        @(negedge clk);
        #1;
    endtask

    task setPc(input logic [15:0] v);
        pcForce = 1'b1;
        pcForceVal = v;
        tick();
        pcForce = 1'b0;
    endtask

    task test_reset;
        Pc_Rst = 1'b0; halt = 1'b1; br_taken = 1'b1; br_target = 16'h1234;
        tick();
        asserts++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b expected 0", ir_valid); end
        asserts++; if (ir_out !== 16'h0000) begin failures++; $display("[TB] FAIL rst_ir_out: got %h expected 0000", ir_out); end
        asserts++; if (ir_pc !== 16'h0000) begin failures++; $display("[TB] FAIL rst_ir_pc: got %h expected 0000", ir_pc); end
        asserts++; if (imem_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err: got %b expected 0", imem_err); end
        asserts++; if (mif.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_req: got %b expected 0", mif.imem_req); end
        asserts++; if (Pc_Ld !== 1'b0) begin failures++; $display("[TB] FAIL rst_pcld: got %b expected 0", Pc_Ld); end
        asserts++; if (Pc_addr_in !== 16'h0000) begin failures++; $display("[TB] FAIL rst_pcaddr: got %h expected 0000", Pc_addr_in); end
        br_taken = 1'b0; Pc_Rst = 1'b1;
        tick();
        asserts++; if (mif.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL halt_idle_req: got %b expected 0", mif.imem_req); end
    endtask

    task test_idle_branch;
        br_taken = 1'b1; br_target = 16'h0200;
        #1;
        asserts++; if (Pc_Ld !== 1'b1) begin failures++; $display("[TB] FAIL idle_br_pcld: got %b expected 1", Pc_Ld); end
        asserts++; if (Pc_addr_in !== 16'h0200) begin failures++; $display("[TB] FAIL idle_br_pcaddr: got %h expected 0200", Pc_addr_in); end
        tick();
        br_taken = 1'b0;
        #1;
        asserts++; if (mif.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL idle_br_req: got %b expected 0", mif.imem_req); end
        asserts++; if (Pc_addr_in !== 16'h0000) begin failures++; $display("[TB] FAIL idle_pcaddr_zero: got %h expected 0000", Pc_addr_in); end
    endtask

    task test_sequential;
        logic [15:0] expData;
        setPc(16'h0000);
        autoAck = 1'b1; ir_ready = 1'b1; halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            asserts++; if (mif.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL seq_req i=%0d: got %b expected 1", i, mif.imem_req); end
            asserts++; if (mif.imem_addr !== 16'(i)) begin failures++; $display("[TB] FAIL seq_addr i=%0d: got %h expected %h", i, mif.imem_addr, 16'(i)); end
            asserts++; if (Pc_Ld !== 1'b1) begin failures++; $display("[TB] FAIL seq_pcld i=%0d: got %b expected 1", i, Pc_Ld); end
            asserts++; if (Pc_addr_in !== 16'(i + 1)) begin failures++; $display("[TB] FAIL seq_pcaddr i=%0d: got %h expected %h", i, Pc_addr_in, 16'(i + 1)); end
            asserts++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL seq_valid_lo i=%0d: got %b expected 0", i, ir_valid); end
            tick();
            expData = ~16'(i);
            asserts++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL seq_valid_hi i=%0d: got %b expected 1", i, ir_valid); end
            asserts++; if (ir_pc !== 16'(i)) begin failures++; $display("[TB] FAIL seq_ir_pc i=%0d: got %h expected %h", i, ir_pc, 16'(i)); end
            asserts++; if (ir_out !== expData) begin failures++; $display("[TB] FAIL seq_ir_out i=%0d: got %h expected %h", i, ir_out, expData); end
            asserts++; if (Pc_Ld !== 1'b0) begin failures++; $display("[TB] FAIL seq_hold_pcld i=%0d: got %b expected 0", i, Pc_Ld); end
            asserts++; if (mif.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL seq_hold_req i=%0d: got %b expected 0", i, mif.imem_req); end
            if (i == 3) halt = 1'b1;
        end
        tick();
        asserts++; if (mif.imem_req !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL seq_stop: got req=%b valid=%b expected 0/0", mif.imem_req, ir_valid); end
    endtask

    task test_backpressure;
        setPc(16'h0004);
        autoAck = 1'b1; ir_ready = 1'b0; halt = 1'b0;
        tick();
        asserts++; if (mif.imem_addr !== 16'h0004) begin failures++; $display("[TB] FAIL bp_addr: got %h expected 0004", mif.imem_addr); end
        tick();
        for (int c = 0; c < 5; c++) begin
            asserts++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid c=%0d: got %b expected 1", c, ir_valid); end
            asserts++; if (ir_out !== 16'hFFFB) begin failures++; $display("[TB] FAIL bp_ir_out c=%0d: got %h expected FFFB", c, ir_out); end
            asserts++; if (ir_pc !== 16'h0004) begin failures++; $display("[TB] FAIL bp_ir_pc c=%0d: got %h expected 0004", c, ir_pc); end
            asserts++; if (mif.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL bp_req c=%0d: got %b expected 0", c, mif.imem_req); end
            asserts++; if (Pc_Ld !== 1'b0) begin failures++; $display("[TB] FAIL bp_pcld c=%0d: got %b expected 0", c, Pc_Ld); end
            tick();
        end
        ir_ready = 1'b1; halt = 1'b1;
        #1;
        asserts++; if (Pc_Ld !== 1'b0) begin failures++; $display("[TB] FAIL bp_accept_pcld: got %b expected 0", Pc_Ld); end
        tick();
        asserts++; if (ir_valid !== 1'b0 || mif.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL bp_release: got valid=%b req=%b expected 0/0", ir_valid, mif.imem_req); end
        ir_ready = 1'b0;
    endtask

    task test_wrap;
        setPc(16'hFFFF);
        autoAck = 1'b1; ir_ready = 1'b1; halt = 1'b0;
        tick();
        halt = 1'b1;
        #1;
        asserts++; if (mif.imem_addr !== 16'hFFFF) begin failures++; $display("[TB] FAIL wrap_addr: got %h expected FFFF", mif.imem_addr); end
        asserts++; if (Pc_Ld !== 1'b1) begin failures++; $display("[TB] FAIL wrap_pcld: got %b expected 1", Pc_Ld); end
        asserts++; if (Pc_addr_in !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_pcaddr: got %h expected 0000", Pc_addr_in); end
        tick();
        asserts++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_halt_completes: got %b expected 1", ir_valid); end
        asserts++; if (ir_pc !== 16'hFFFF) begin failures++; $display("[TB] FAIL wrap_ir_pc: got %h expected FFFF", ir_pc); end
        asserts++; if (ir_out !== 16'h0000) begin failures++; $display("[TB] FAIL wrap_ir_out: got %h expected 0000", ir_out); end
        tick();
        asserts++; if (mif.imem_req !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL wrap_idle: got req=%b valid=%b expected 0/0", mif.imem_req, ir_valid); end
        ir_ready = 1'b0;
    endtask

    task test_branch_flush;
        setPc(16'h0010);
        autoAck = 1'b0; manualAck = 1'b0; ir_ready = 1'b0; halt = 1'b0;
        tick();
        br_taken = 1'b1; br_target = 16'h0040;
        #1;
        asserts++; if (Pc_Ld !== 1'b1 || Pc_addr_in !== 16'h0040) begin failures++; $display("[TB] FAIL brf_load: got ld=%b addr=%h expected 1/0040", Pc_Ld, Pc_addr_in); end
        tick();
        br_taken = 1'b0;
        #1;
        asserts++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0010) begin failures++; $display("[TB] FAIL brf_flush_req: got req=%b addr=%h expected 1/0010", mif.imem_req, mif.imem_addr); end
        asserts++; if (Pc_Ld !== 1'b0) begin failures++; $display("[TB] FAIL brf_flush_pcld: got %b expected 0", Pc_Ld); end
        tick();
        asserts++; if (mif.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL brf_flush_wait: got %b expected 1", mif.imem_req); end
        tick();
        manualAck = 1'b1; manualData = 16'hDEAD;
        #1;
        asserts++; if (Pc_Ld !== 1'b0 || mif.imem_addr !== 16'h0010) begin failures++; $display("[TB] FAIL brf_discard: got ld=%b addr=%h expected 0/0010", Pc_Ld, mif.imem_addr); end
        tick();
        manualAck = 1'b0;
        #1;
        asserts++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0040) begin failures++; $display("[TB] FAIL brf_refetch: got req=%b addr=%h expected 1/0040", mif.imem_req, mif.imem_addr); end
        asserts++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL brf_no_valid: got %b expected 0", ir_valid); end
        manualAck = 1'b1; manualData = 16'h1234; ir_ready = 1'b1; halt = 1'b1;
        #1;
        asserts++; if (Pc_Ld !== 1'b1 || Pc_addr_in !== 16'h0041) begin failures++; $display("[TB] FAIL brf_next_pc: got ld=%b addr=%h expected 1/0041", Pc_Ld, Pc_addr_in); end
        tick();
        manualAck = 1'b0;
        asserts++; if (ir_valid !== 1'b1 || ir_out !== 16'h1234 || ir_pc !== 16'h0040) begin failures++; $display("[TB] FAIL brf_ir: got v=%b out=%h pc=%h expected 1/1234/0040", ir_valid, ir_out, ir_pc); end
        tick();
        asserts++; if (ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL brf_done: got %b expected 0", ir_valid); end
        ir_ready = 1'b0;
    endtask

    task test_branch_redirect;
        setPc(16'h0100);
        autoAck = 1'b1; ir_ready = 1'b0; halt = 1'b0;
        tick();
        tick();
        br_taken = 1'b1; br_target = 16'h0300;
        #1;
        asserts++; if (ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL brh_valid: got %b expected 1", ir_valid); end
        asserts++; if (Pc_Ld !== 1'b1 || Pc_addr_in !== 16'h0300) begin failures++; $display("[TB] FAIL brh_load: got ld=%b addr=%h expected 1/0300", Pc_Ld, Pc_addr_in); end
        tick();
        asserts++; if (ir_valid !== 1'b0 || mif.imem_addr !== 16'h0300) begin failures++; $display("[TB] FAIL brh_drop: got v=%b addr=%h expected 0/0300", ir_valid, mif.imem_addr); end
        br_target = 16'h0500;
        #1;
        asserts++; if (Pc_Ld !== 1'b1 || Pc_addr_in !== 16'h0500) begin failures++; $display("[TB] FAIL bra_load: got ld=%b addr=%h expected 1/0500", Pc_Ld, Pc_addr_in); end
        tick();
        br_taken = 1'b0;
        #1;
        asserts++; if (mif.imem_addr !== 16'h0500 || ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL bra_refetch: got addr=%h v=%b expected 0500/0", mif.imem_addr, ir_valid); end
        asserts++; if (Pc_addr_in !== 16'h0501) begin failures++; $display("[TB] FAIL bra_next_pc: got %h expected 0501", Pc_addr_in); end
        ir_ready = 1'b1; halt = 1'b1;
        tick();
        asserts++; if (ir_pc !== 16'h0500 || ir_out !== 16'hFAFF) begin failures++; $display("[TB] FAIL bra_ir: got pc=%h out=%h expected 0500/FAFF", ir_pc, ir_out); end
        tick();
        asserts++; if (mif.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL bra_idle: got %b expected 0", mif.imem_req); end
        ir_ready = 1'b0;
    endtask

    task test_timeout;
        setPc(16'h0080);
        autoAck = 1'b0; manualAck = 1'b0; halt = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            asserts++; if (imem_err !== 1'b0 || mif.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL to_wait k=%0d: got err=%b req=%b expected 0/1", k, imem_err, mif.imem_req); end
        end
        tick();
        asserts++; if (imem_err !== 1'b1) begin failures++; $display("[TB] FAIL to_err: got %b expected 1", imem_err); end
        asserts++; if (mif.imem_req !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("[TB] FAIL to_quiet: got req=%b v=%b expected 0/0", mif.imem_req, ir_valid); end
        br_taken = 1'b1; br_target = 16'h0077; manualAck = 1'b1; ir_ready = 1'b1;
        #1;
        asserts++; if (Pc_Ld !== 1'b0 || Pc_addr_in !== 16'h0000) begin failures++; $display("[TB] FAIL to_ignore_br: got ld=%b addr=%h expected 0/0000", Pc_Ld, Pc_addr_in); end
        tick();
        asserts++; if (imem_err !== 1'b1 || mif.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL to_sticky: got err=%b req=%b expected 1/0", imem_err, mif.imem_req); end
        br_taken = 1'b0; manualAck = 1'b0; ir_ready = 1'b0; halt = 1'b1;
        Pc_Rst = 1'b0;
        #1;
        asserts++; if (imem_err !== 1'b0) begin failures++; $display("[TB] FAIL to_rst_clear: got %b expected 0", imem_err); end
        tick();
        Pc_Rst = 1'b1;
        tick();
        asserts++; if (imem_err !== 1'b0 || mif.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL to_after_rst: got err=%b req=%b expected 0/0", imem_err, mif.imem_req); end
    endtask

    task test_reset_mid_hold;
        setPc(16'h0020);
        autoAck = 1'b1; ir_ready = 1'b0; halt = 1'b0;
        tick();
        tick();
        asserts++; if (ir_valid !== 1'b1 || ir_pc !== 16'h0020) begin failures++; $display("[TB] FAIL rmh_hold: got v=%b pc=%h expected 1/0020", ir_valid, ir_pc); end
        #1;
        Pc_Rst = 1'b0;
        #1;
        asserts++; if (ir_valid !== 1'b0 || ir_pc !== 16'h0000 || ir_out !== 16'h0000) begin failures++; $display("[TB] FAIL rmh_async: got v=%b pc=%h out=%h expected 0/0000/0000", ir_valid, ir_pc, ir_out); end
        asserts++; if (mif.imem_req !== 1'b0 || Pc_Ld !== 1'b0) begin failures++; $display("[TB] FAIL rmh_idle: got req=%b ld=%b expected 0/0", mif.imem_req, Pc_Ld); end
        ir_ready = 1'b1;
        tick();
        Pc_Rst = 1'b1;
        tick();
        asserts++; if (mif.imem_req !== 1'b1 || mif.imem_addr !== 16'h0021) begin failures++; $display("[TB] FAIL rmh_refetch: got req=%b addr=%h expected 1/0021", mif.imem_req, mif.imem_addr); end
        halt = 1'b1;
        tick();
        asserts++; if (ir_pc !== 16'h0021 || ir_valid !== 1'b1) begin failures++; $display("[TB] FAIL rmh_ir: got pc=%h v=%b expected 0021/1", ir_pc, ir_valid); end
        tick();
        ir_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] instr_fetch directed test start");
        test_reset();
        test_idle_branch();
        test_sequential();
        test_backpressure();
        test_wrap();
        test_branch_flush();
        test_branch_redirect();
        test_timeout();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_STEP, default 16'd1, increment added to the PC per sequential fetch (word addressing).
REQ-002 SHALL have parameter MAX_WAIT, default 15, maximum cycles to wait for imem_ack before flagging an error.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port Pc_Rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port inst_addr  input  16  current PC value from the program counter.
REQ-006 SHALL have port Pc_Ld  output  1  PC load strobe, combinational.
REQ-007 SHALL have port Pc_addr_in  output  16  next PC value, combinational.
REQ-008 SHALL have port imem_req / imem_addr  output  1 / 16  instruction memory request and address.
REQ-009 SHALL have port imem_ack / imem_rdata  input  1 / 16  memory acknowledge and read data, valid together.
REQ-010 SHALL have port ir_out / ir_pc  output  16 / 16  fetched instruction and its address.
REQ-011 SHALL have port ir_valid  output  1  ir_out holds an instruction for the decoder.
REQ-012 SHALL have port ir_ready  input  1  decoder accepts ir_out in this cycle.
REQ-013 SHALL have port br_taken / br_target  input  1 / 16  redirect request and destination.
REQ-014 SHALL have port halt  input  1  stop issuing new fetches.
REQ-015 SHALL have port imem_err  output  1  sticky memory-timeout flag.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, HOLD, FLUSH and ERROR.
REQ-017 IDLE SHALL go to FETCH on the next edge when halt=0, and SHALL stay in IDLE otherwise.
REQ-018 On entry to FETCH, fetch_addr SHALL latch inst_addr; imem_addr SHALL equal fetch_addr, stable until ack.
REQ-019 imem_req SHALL be 1 in FETCH and FLUSH and 0 in all other states.
REQ-020 On FETCH with imem_ack=1 and br_taken=0, the block SHALL drive Pc_Ld=1 and Pc_addr_in=fetch_addr+PC_STEP (mod 2^16, 16'hFFFF+1 gives 16'h0000), capture ir_out=imem_rdata and ir_pc=fetch_addr, set ir_valid=1, and go to HOLD.
REQ-021 In HOLD, when ir_valid=1 and ir_ready=1 the transfer SHALL complete: ir_valid clears and the FSM goes to FETCH, or to IDLE if halt=1.
REQ-022 In HOLD with ir_ready=0, ir_out, ir_pc and ir_valid SHALL hold their values.
REQ-023 Minimum throughput SHALL be one instruction per 2 cycles, with a zero-wait ack.
REQ-024 br_taken=1 SHALL have priority in every state except ERROR: Pc_Ld=1 and Pc_addr_in=br_target in that cycle.
REQ-025 br_taken in HOLD SHALL clear ir_valid on the next edge, drop the instruction, and go to FETCH.
REQ-026 br_taken in FETCH with imem_ack=1 in the same cycle SHALL discard the data and go to FETCH, which re-latches the address.
REQ-027 br_taken in FETCH with imem_ack=0 SHALL go to FLUSH.
REQ-028 FLUSH SHALL keep the request at the old fetch_addr until ack, discard the data, then go to FETCH.
REQ-029 br_taken in IDLE SHALL load the PC and leave the FSM in IDLE.
REQ-030 Outside REQ-020 and REQ-024, Pc_Ld SHALL be 0 and Pc_addr_in SHALL be 16'd0.
REQ-031 The wait counter SHALL count the cycles spent in FETCH/FLUSH without ack, and SHALL clear on ack and on state entry.
REQ-032 When the wait count reaches MAX_WAIT, the block SHALL set imem_err=1 and go to ERROR.
REQ-033 ERROR SHALL drive imem_req=0, ir_valid=0 and Pc_Ld=0, ignore all inputs, and exit only on reset.
REQ-034 halt asserted during FETCH or FLUSH SHALL let the outstanding access complete and SHALL take effect at the HOLD exit.

Reset
REQ-035 Pc_Rst=0 SHALL immediately force state=IDLE, ir_out=0, ir_pc=0, ir_valid=0, fetch_addr=0, wait count=0 and imem_err=0.
REQ-036 During reset, imem_req and Pc_Ld SHALL be 0.
REQ-037 Reset asserted mid-access SHALL abandon the access; the first post-reset fetch SHALL be at inst_addr.

Structure
REQ-038 Package fetch_pkg SHALL hold the state encoding, PC_STEP default, MAX_WAIT default and a 16-bit address type.
REQ-039 The timeout counter SHALL be a sub-module, fetch_wait_timer (inputs clear/enable, output expired), with reset Pc_Rst.
REQ-040 The PC register SHALL remain external; this block SHALL only drive Pc_Ld/Pc_addr_in.

Verification
REQ-041 Sequential test: PC=0, zero-wait ack, ir_ready=1 -> ir_pc sequence 0,1,2,3; Pc_Ld pulses once per fetch; ir_valid every 2nd cycle.
REQ-042 Backpressure test: ir_ready=0 for 5 cycles in HOLD -> ir_out stable, no new imem_req, Pc_Ld=0.
REQ-043 Branch test: br_taken with br_target=16'h0040 in FETCH, ack 3 cycles later -> FLUSH, data discarded, next imem_addr=16'h0040.
REQ-044 Wrap test: inst_addr=16'hFFFF -> Pc_addr_in=16'h0000.
REQ-045 Timeout test: imem_ack held 0 -> imem_err=1 after 15 waiting cycles, imem_req=0; Pc_Rst pulse clears imem_err.
REQ-046 Reset test: Pc_Rst low mid-HOLD -> ir_valid=0 and state IDLE asynchronously, without waiting for clk.
